// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

  // Clear sequence runs first, then normal operation.
  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  // Entry that reads as zero when the zero register is enabled.
  localparam int REG_ZERO_ADDR = 0;

  // Default geometry of the datapath.
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

endpackage

// File: rtl/regfile_read_port.sv
// One read lane: zero register, write bypass priority and clear masking.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        stored_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     ready,
  output logic [DATA_W-1:0]        rd_data
);

  // Priority: clear masking, then zero register, then highest matching
  // write port (bypass), then the stored value.
  always_comb begin
    rd_data = stored_data;
    if (BYPASS != 0) begin
      // Ascending scan so the highest-numbered matching port is the last
      // assignment and therefore wins.
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == rd_addr)) begin
          rd_data = wr_data[k*DATA_W +: DATA_W];
        end
      end
    end
    if ((ZERO_REG != 0) && (rd_addr == ADDR_W'(REG_ZERO_ADDR))) begin
      rd_data = '0;
    end
    if (!ready) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/multi_port_regfile.sv
// Parametrised register file with N read / M write ports, optional bypass,
// and a hardware clear sequence that runs after every reset.
module multi_port_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     ready,
  output logic                     wr_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              ready_q, ready_d;
  logic              wr_conflict_q, wr_conflict_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // State register; reset restarts the clear from entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RF_CLEAR;
      clr_idx_q     <= '0;
      ready_q       <= 1'b0;
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_idx_q     <= clr_idx_d;
      ready_q       <= ready_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Next-state: walk every entry once in CLEAR, then stay in READY.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      RF_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == {ADDR_W{1'b1}}) begin
          state_d = RF_READY;
        end
      end
      RF_READY: begin
        state_d = RF_READY;
      end
      default: begin
        state_d = RF_CLEAR;
      end
    endcase
    if (reset) begin
      state_d   = RF_CLEAR;
      clr_idx_d = '0;
    end
  end

  // Registered outputs: ready tracks entry into READY on the same edge,
  // wr_conflict flags a same-address multi-port write one cycle later.
  always_comb begin
    ready_d       = (state_d == RF_READY);
    wr_conflict_d = 1'b0;
    if (state_q == RF_READY) begin
      for (int i = 0; i < NUM_WR; i++) begin
        for (int j = i + 1; j < NUM_WR; j++) begin
          if (wr_en[i] && wr_en[j] &&
              (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W]) &&
              (wr_addr[i*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO_ADDR))) begin
            wr_conflict_d = 1'b1;
          end
        end
      end
    end
  end

  // Storage update: clear one entry per cycle in CLEAR, otherwise apply
  // writes in ascending port order so the highest port wins a collision.
  always_comb begin
    mem_d = mem_q;
    if (state_q == RF_CLEAR) begin
      mem_d[clr_idx_q] = '0;
    end else if (!reset) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] &&
            !((ZERO_REG != 0) &&
              (wr_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO_ADDR)))) begin
          mem_d[wr_addr[k*ADDR_W +: ADDR_W]] = wr_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Storage array; contents are defined by the clear sequence, not by reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ready       = ready_q;
  assign wr_conflict = wr_conflict_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      regfile_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_WR  (NUM_WR),
        .BYPASS  (BYPASS),
        .ZERO_REG(ZERO_REG)
      ) u_rd (
        .rd_addr    (rd_addr[gi*ADDR_W +: ADDR_W]),
        .stored_data(mem_q[rd_addr[gi*ADDR_W +: ADDR_W]]),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ready      (ready_q),
        .rd_data    (rd_data[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_port_regfile.sv
// Bench: two 4-read/2-write instances (bypass on and off) driven in parallel.
module tb_multi_port_regfile;

  logic         clk;
  logic         reset;
  logic [1:0]   wr_en;
  logic [9:0]   wr_addr;
  logic [63:0]  wr_data;
  logic [19:0]  rd_addr;
  logic [127:0] rd_data_bp, rd_data_nb;
  logic         ready_bp, ready_nb;
  logic         conf_bp, conf_nb;

  int checks = 0;
  int errors = 0;

  multi_port_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .NUM_WR(2),
                       .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_bp),
    .ready(ready_bp), .wr_conflict(conf_bp)
  );

  multi_port_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .NUM_WR(2),
                       .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .ready(ready_nb), .wr_conflict(conf_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1, ra2, ra3;
    logic [31:0] e0, e1, e2, e3;
  } vec_t;

  typedef struct packed {
    logic [3:0][31:0] bp;
    logic [3:0][31:0] nb;
    logic             conf;
  } exp_t;

  vec_t        vecs [15];
  exp_t        sb_q [$];
  logic [31:0] mem_m [32];

  function automatic vec_t mkv(input logic [1:0] we, input logic [4:0] wa0,
                               input logic [31:0] wd0, input logic [4:0] wa1,
                               input logic [31:0] wd1, input logic [4:0] ra0,
                               input logic [4:0] ra1, input logic [4:0] ra2,
                               input logic [4:0] ra3, input logic [31:0] e0,
                               input logic [31:0] e1, input logic [31:0] e2,
                               input logic [31:0] e3);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2; v.ra3 = ra3;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 2'b00; wr_addr = '0; wr_data = '0;
  endtask

  // One-cycle reset pulse; returns 1ns after the reset edge.
  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // Checks ready low for 31 cycles after the reset edge and high on the
  // 32nd; reads must be zero throughout the clear.
  task automatic check_clear(input string tag);
    for (int i = 0; i <= 32; i++) begin
      rd_addr = {5'(i + 3), 5'(i + 2), 5'(i + 1), 5'(i)};
      @(negedge clk);
      chk($sformatf("%s ready_bp c%0d", tag, i), {31'b0, ready_bp}, {31'b0, i == 32});
      chk($sformatf("%s ready_nb c%0d", tag, i), {31'b0, ready_nb}, {31'b0, i == 32});
      if (i < 32) begin
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("%s clr_rd_bp c%0d l%0d", tag, i, k), rd_data_bp[k*32 +: 32], 32'h0);
          chk($sformatf("%s clr_rd_nb c%0d l%0d", tag, i, k), rd_data_nb[k*32 +: 32], 32'h0);
        end
        chk($sformatf("%s clr_conf c%0d", tag, i), {31'b0, conf_bp}, 32'h0);
      end
    end
    $display("%s: clear sequence observed", tag);
  endtask

  // Reads every entry on all lanes of both instances; all must be zero.
  task automatic check_all_zero(input string tag);
    idle_inputs();
    for (int g = 0; g < 8; g++) begin
      @(posedge clk); #1;
      rd_addr = {5'(g*4 + 3), 5'(g*4 + 2), 5'(g*4 + 1), 5'(g*4)};
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("%s r%0d bp", tag, g*4 + k), rd_data_bp[k*32 +: 32], 32'h0);
        chk($sformatf("%s r%0d nb", tag, g*4 + k), rd_data_nb[k*32 +: 32], 32'h0);
      end
    end
    $display("%s: all 32 entries read back", tag);
  endtask

  initial begin
    logic prev_conf;
    exp_t e;
    vec_t v;

    reset = 1'b0;
    rd_addr = '0;
    idle_inputs();

    // bp expectations are hand-derived same-cycle (bypass) values.
    vecs[0]  = mkv(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,    5'd5, 5'd0, 5'd1, 5'd2,
                   32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    vecs[1]  = mkv(2'b00, 5'd0, 32'h0, 5'd0, 32'h0,           5'd5, 5'd0, 5'd1, 5'd2,
                   32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    vecs[2]  = mkv(2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0,    5'd0, 5'd0, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'h0, 32'h0);
    vecs[3]  = mkv(2'b00, 5'd0, 32'h0, 5'd0, 32'h0,           5'd0, 5'd0, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'h0, 32'h0);
    vecs[4]  = mkv(2'b11, 5'd7, 32'h1111, 5'd7, 32'h2222,     5'd7, 5'd7, 5'd5, 5'd0,
                   32'h2222, 32'h2222, 32'hDEADBEEF, 32'h0);
    vecs[5]  = mkv(2'b00, 5'd0, 32'h0, 5'd0, 32'h0,           5'd7, 5'd5, 5'd7, 5'd0,
                   32'h2222, 32'hDEADBEEF, 32'h2222, 32'h0);
    vecs[6]  = mkv(2'b00, 5'd0, 32'h0, 5'd0, 32'h0,           5'd7, 5'd7, 5'd7, 5'd7,
                   32'h2222, 32'h2222, 32'h2222, 32'h2222);
    vecs[7]  = mkv(2'b11, 5'd1, 32'hA, 5'd2, 32'hB,           5'd1, 5'd2, 5'd1, 5'd0,
                   32'hA, 32'hB, 32'hA, 32'h0);
    vecs[8]  = mkv(2'b00, 5'd0, 32'h0, 5'd0, 32'h0,           5'd1, 5'd2, 5'd1, 5'd0,
                   32'hA, 32'hB, 32'hA, 32'h0);
    vecs[9]  = mkv(2'b11, 5'd0, 32'h5, 5'd0, 32'h6,           5'd0, 5'd0, 5'd1, 5'd2,
                   32'h0, 32'h0, 32'hA, 32'hB);
    vecs[10] = mkv(2'b11, 5'd10, 32'h77, 5'd9, 32'h99,        5'd9, 5'd10, 5'd7, 5'd1,
                   32'h99, 32'h77, 32'h2222, 32'hA);
    vecs[11] = mkv(2'b11, 5'd7, 32'h3333, 5'd7, 32'h4444,     5'd7, 5'd9, 5'd10, 5'd0,
                   32'h4444, 32'h99, 32'h77, 32'h0);
    vecs[12] = mkv(2'b11, 5'd7, 32'h5555, 5'd7, 32'h6666,     5'd7, 5'd7, 5'd2, 5'd1,
                   32'h6666, 32'h6666, 32'hB, 32'hA);
    vecs[13] = mkv(2'b00, 5'd0, 32'h0, 5'd0, 32'h0,           5'd7, 5'd1, 5'd2, 5'd0,
                   32'h6666, 32'hA, 32'hB, 32'h0);
    vecs[14] = mkv(2'b00, 5'd0, 32'h0, 5'd0, 32'h0,           5'd7, 5'd9, 5'd10, 5'd5,
                   32'h6666, 32'h99, 32'h77, 32'hDEADBEEF);

    // Reset and full clear.
    pulse_reset();
    check_clear("reset1");
    check_all_zero("after_clear1");
    for (int a = 0; a < 32; a++) mem_m[a] = 32'h0;

    // Table-driven vectors through the scoreboard.
    prev_conf = 1'b0;
    for (int n = 0; n < 15; n++) begin
      v = vecs[n];
      @(posedge clk); #1;
      wr_en   = v.we;
      wr_addr = {v.wa1, v.wa0};
      wr_data = {v.wd1, v.wd0};
      rd_addr = {v.ra3, v.ra2, v.ra1, v.ra0};
      e.bp   = {v.e3, v.e2, v.e1, v.e0};
      e.nb   = {(v.ra3 == 0) ? 32'h0 : mem_m[v.ra3], (v.ra2 == 0) ? 32'h0 : mem_m[v.ra2],
                (v.ra1 == 0) ? 32'h0 : mem_m[v.ra1], (v.ra0 == 0) ? 32'h0 : mem_m[v.ra0]};
      e.conf = prev_conf;
      sb_q.push_back(e);
      // Reference model: writes land at the coming edge, port 1 last.
      if (v.we[0] && v.wa0 != 0) mem_m[v.wa0] = v.wd0;
      if (v.we[1] && v.wa1 != 0) mem_m[v.wa1] = v.wd1;
      prev_conf = (v.we == 2'b11) && (v.wa0 == v.wa1) && (v.wa0 != 0);

      @(negedge clk);
      e = sb_q.pop_front();
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("v%0d bp lane%0d", n, k), rd_data_bp[k*32 +: 32], e.bp[k]);
        chk($sformatf("v%0d nb lane%0d", n, k), rd_data_nb[k*32 +: 32], e.nb[k]);
      end
      chk($sformatf("v%0d conf_bp", n), {31'b0, conf_bp}, {31'b0, e.conf});
      chk($sformatf("v%0d conf_nb", n), {31'b0, conf_nb}, {31'b0, e.conf});
      chk($sformatf("v%0d ready", n), {31'b0, ready_bp}, 32'h1);
      $display("vec %0d we=%b wa=%0d/%0d rd=%h/%h/%h/%h conf=%b", n, v.we, v.wa0, v.wa1,
               rd_data_bp[31:0], rd_data_bp[63:32], rd_data_bp[95:64], rd_data_bp[127:96],
               conf_bp);
    end
    idle_inputs();

    // Reset mid-clear with a write to r3 attempted during the clear.
    pulse_reset();
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 4) begin
        wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'hCAFE0001, 32'hCAFE0000};
      end else begin
        idle_inputs();
      end
      if (c == 10) reset = 1'b1;
      @(negedge clk);
      chk($sformatf("midclr ready c%0d", c), {31'b0, ready_bp}, 32'h0);
      chk($sformatf("midclr conf c%0d", c), {31'b0, conf_bp}, 32'h0);
    end
    @(posedge clk); #1 reset = 1'b0;
    check_clear("reset2");
    check_all_zero("after_clear2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multi_port_regfile.md
# multi_port_regfile

Parametrised general-purpose register file for the pipeline CPU. It is the successor to the fixed 2-read/1-write, 32×32 file, and adds:
- a configurable number of read and write ports;
- optional same-cycle write-to-read bypass, so the decode stage sees writeback data without an external forwarding mux;
- a deterministic hardware clear sequence after reset, with a `ready` handshake to the pipeline control.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; depth = 2**ADDR_W entries
- `NUM_RD`, 2, number of read ports (1..4)
- `NUM_WR`, 1, number of write ports (1..2)
- `BYPASS`, 1, 1 = read returns same-cycle write data on address match; 0 = read returns stored value
- `ZERO_REG`, 1, 1 = entry 0 is hardwired to zero
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `wr_en`  in  NUM_WR  per-port write enable
- `wr_addr`  in  NUM_WR*ADDR_W  packed write addresses; port k at bits [k*ADDR_W +: ADDR_W]
- `wr_data`  in  NUM_WR*DATA_W  packed write data
- `rd_addr`  in  NUM_RD*ADDR_W  packed read addresses
- `rd_data`  out  NUM_RD*DATA_W  packed read data; combinational from `rd_addr` and state
- `ready`  out  1  high when the file accepts writes and returns valid reads
- `wr_conflict`  out  1  registered pulse: two enabled write ports targeted the same nonzero address in the previous cycle

## Operation
- **States.**
  - CLEAR: entered on `reset`. A clear counter `clr_idx` (ADDR_W bits) starts at 0 and writes zero to entry `clr_idx` each cycle. Leave CLEAR the cycle after `clr_idx` = 2**ADDR_W−1 is cleared.
  - READY: normal operation; stays here until `reset`.
- **Reset.** `reset` in any state, including mid-CLEAR, forces CLEAR with `clr_idx` = 0 on the next edge.
- **CLEAR behaviour.**
  - All `wr_en` are ignored.
  - `rd_data` returns all zeros.
  - `ready` = 0.
- **Writes (READY only).** Each port with `wr_en`=1 writes `wr_data` to `wr_addr` at the rising edge.
  - If `ZERO_REG`=1, writes to address 0 are dropped.
  - If two ports hit the same address, the highest-numbered port wins.
- **Reads.**
  - `ZERO_REG`=1 and address 0 → 0.
  - Otherwise, if `BYPASS`=1 and an enabled write port matches the read address this cycle (READY only) → that port's `wr_data`, using the highest-numbered matching port.
  - Otherwise → stored entry.
- **`wr_conflict`.** Set at the edge following a same-address dual write to a nonzero address (READY only). Cleared the next cycle unless the condition repeats. Held at 0 in CLEAR.

## Timing
- Reset values: `ready`=0, `wr_conflict`=0, `rd_data`=0 (all lanes), `clr_idx`=0.
- Clear latency: `ready` rises exactly 2**ADDR_W cycles after the last edge with `reset`=1 (32 cycles at defaults).
- Write-to-read latency:
  - 0 cycles with `BYPASS`=1;
  - 1 cycle (the value is visible after the edge) with `BYPASS`=0.
- Read path is purely combinational; no read enable and no read latency.
- `wr_conflict` lags the offending writes by 1 cycle.
- `ready` is a registered output: it is low on the first edge after `reset`, and it rises on the same edge at which the file enters READY.

## Structure
- Shared package `regfile_pkg`:
  - FSM state enum {`RF_CLEAR`, `RF_READY`};
  - `REG_ZERO_ADDR` constant;
  - default `DATA_W`/`ADDR_W` constants reused by the datapath.
- One sub-module, `regfile_read_port`, instantiated NUM_RD times by generate. It holds the zero-register, bypass-priority and CLEAR masking logic for one lane.
- The storage array, clear FSM, write arbitration and conflict detector stay in the top module.

## Test plan
- **Reset and clear.** Pulse `reset` 1 cycle with defaults → `ready`=0 for 32 cycles, then 1. Every read during the clear returns 0, and all 32 entries read 0 afterwards.
- **Basic write/read.** In READY, write 0xDEADBEEF to r5.
  - `BYPASS`=1: `rd_data` lane 0 shows it in the same cycle.
  - `BYPASS`=0: it appears 1 cycle later.
- **Zero register.** Write 0x12345678 to r0 → reads of r0 on all ports return 0, both in that cycle and afterwards.
- **Dual-write collision.** `NUM_WR`=2, port0 writes 0x1111 and port1 writes 0x2222, both to r7 → r7 = 0x2222. `wr_conflict`=1 for exactly one cycle, on the following cycle.
- **Reset mid-clear.** Assert `reset` at clear cycle 10 → the clear restarts from 0 and `ready` rises 32 cycles after the second reset. A write to r3 issued during the clear is lost (r3 reads 0).
- **Multi-port reads.** `NUM_RD`=4 reading r1, r2, r1, r0 after writing 0xA and 0xB to r1 and r2 → lanes return 0xA, 0xB, 0xA, 0.
